// File: rtl/scandoubler_timing_if.sv
// Video timing bundle between the source side and the scandoubler timing controller.
// The slave modport is the controller; the master modport is the source/consumer side.
interface scandoubler_timing_if #(
    parameter int HCNT_WIDTH = 10
);
    logic                  bypass;
    logic                  ce_x1;
    logic                  ce_x2;
    logic                  hs_in;
    logic                  vs_in;
    logic                  pe_in;
    logic                  pe_out;
    logic [HCNT_WIDTH-1:0] hcnt;
    logic [HCNT_WIDTH-1:0] sd_hcnt;
    logic                  line_toggle;
    logic                  hs_sd;
    logic                  vs_sd;
    logic [HCNT_WIDTH-1:0] line_len;
    logic [HCNT_WIDTH-1:0] hs_len;
    logic                  locked;
    logic                  overflow;

    modport master (
        output bypass, ce_x1, ce_x2, hs_in, vs_in,
        input  pe_in, pe_out, hcnt, sd_hcnt, line_toggle, hs_sd, vs_sd,
               line_len, hs_len, locked, overflow
    );

    modport slave (
        input  bypass, ce_x1, ce_x2, hs_in, vs_in,
        output pe_in, pe_out, hcnt, sd_hcnt, line_toggle, hs_sd, vs_sd,
               line_len, hs_len, locked, overflow
    );
endinterface

// File: rtl/scandoubler_timing.sv
// Scandoubler timing controller: measures input line/hsync length and generates
// write/read counters, buffer half-select and doubled-rate sync for the line buffer.
module scandoubler_timing #(
    parameter int HCNT_WIDTH = 10,
    parameter int LOCK_LINES = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    scandoubler_timing_if.slave   sd
);
    localparam logic [HCNT_WIDTH-1:0] MAX = '1;
    localparam int CW = $clog2(LOCK_LINES + 1);

    typedef enum logic {UNLOCKED, LOCKED} lockState_t;

    logic                  r_hsPrev;
    logic [HCNT_WIDTH-1:0] r_hcnt;
    logic [HCNT_WIDTH-1:0] r_lineLen;
    logic [HCNT_WIDTH-1:0] r_hsLen;
    logic                  r_lineToggle;
    logic                  r_overflow;
    logic [HCNT_WIDTH-1:0] r_sdHcnt;
    logic                  r_pending;
    logic                  r_hsSd;
    logic                  r_vsSd;
    lockState_t            r_state;
    logic [CW-1:0]         r_matchCnt;

    logic                  w_hsRise;
    logic                  w_hsFall;
    logic                  w_satEvent;
    logic                  w_match;
    logic                  w_peOut;
    logic [HCNT_WIDTH-1:0] w_hcntNext;
    logic [HCNT_WIDTH-1:0] w_sdNext;
    lockState_t            w_stateNext;
    logic [CW-1:0]         w_matchCntNext;

    assign w_hsRise   = sd.ce_x1 & sd.hs_in & ~r_hsPrev;
    assign w_hsFall   = sd.ce_x1 & ~sd.hs_in & r_hsPrev;
    assign w_satEvent = sd.ce_x1 & ~w_hsRise & (r_hcnt == MAX);
    assign w_match    = (r_hcnt == r_lineLen);
    assign w_peOut    = sd.bypass ? sd.ce_x1 : sd.ce_x2;

    always_comb begin
        w_hcntNext = r_hcnt;
        if (sd.ce_x1) begin
            if (w_hsRise)
                w_hcntNext = '0;
            else if (r_hcnt != MAX)
                w_hcntNext = r_hcnt + 1'b1;
        end
    end

    // Input side: the write counter saturates instead of wrapping so a runaway line is flagged.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hsPrev     <= 1'b0;
            r_hcnt       <= '0;
            r_lineLen    <= '0;
            r_hsLen      <= '0;
            r_lineToggle <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (sd.ce_x1) begin
            r_hsPrev <= sd.hs_in;
            r_hcnt   <= w_hcntNext;
            if (w_hsRise) begin
                r_lineLen    <= r_hcnt;
                r_lineToggle <= ~r_lineToggle;
            end
            if (w_satEvent)
                r_overflow <= 1'b1;
            if (w_hsFall)
                r_hsLen <= (r_hcnt == MAX) ? MAX : r_hcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= UNLOCKED;
            r_matchCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_matchCnt <= w_matchCntNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_matchCntNext = r_matchCnt;
        if (w_satEvent) begin
            w_stateNext    = UNLOCKED;
            w_matchCntNext = '0;
        end else if (w_hsRise) begin
            case (r_state)
                UNLOCKED: begin
                    if (!w_match) begin
                        w_matchCntNext = '0;
                    end else if (r_matchCnt == CW'(LOCK_LINES - 1)) begin
                        w_stateNext    = LOCKED;
                        w_matchCntNext = '0;
                    end else begin
                        w_matchCntNext = r_matchCnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_match) begin
                        w_stateNext    = UNLOCKED;
                        w_matchCntNext = '0;
                    end
                end
                default: begin
                    w_stateNext    = UNLOCKED;
                    w_matchCntNext = '0;
                end
            endcase
        end
    end

    always_comb begin
        sd.locked = (r_state == LOCKED);
    end

    // Read counter restarts on every input line so the two output lines stay aligned to it.
    always_comb begin
        w_sdNext = r_sdHcnt;
        if (sd.bypass) begin
            if (sd.ce_x1)
                w_sdNext = w_hcntNext;
        end else if (sd.ce_x2) begin
            if (w_hsRise || r_pending)
                w_sdNext = '0;
            else if (r_sdHcnt == r_lineLen)
                w_sdNext = '0;
            else
                w_sdNext = r_sdHcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sdHcnt  <= '0;
            r_pending <= 1'b0;
            r_hsSd    <= 1'b0;
            r_vsSd    <= 1'b0;
        end else if (w_peOut) begin
            r_sdHcnt  <= w_sdNext;
            r_pending <= 1'b0;
            if (sd.bypass) begin
                r_hsSd <= sd.hs_in;
                r_vsSd <= sd.vs_in;
            end else begin
                r_hsSd <= (w_sdNext < r_hsLen);
                if (w_sdNext == '0)
                    r_vsSd <= sd.vs_in;
            end
        end else if (w_hsRise) begin
            r_pending <= 1'b1;
        end
    end

    assign sd.pe_in       = sd.ce_x1;
    assign sd.pe_out      = w_peOut;
    assign sd.hcnt        = r_hcnt;
    assign sd.sd_hcnt     = r_sdHcnt;
    assign sd.line_toggle = r_lineToggle;
    assign sd.hs_sd       = r_hsSd;
    assign sd.vs_sd       = r_vsSd;
    assign sd.line_len    = r_lineLen;
    assign sd.hs_len      = r_hsLen;
    assign sd.overflow    = r_overflow;
endmodule

// File: doc/scandoubler_timing.md
Name: scandoubler_timing

Overview:
Timing controller that sequences the scandoubler line-doubling datapath. It measures the incoming line length and hsync width from the source video. It then generates the write counter (hcnt), the read counter (sd_hcnt), the buffer half-select (line_toggle), the pixel enables and the doubled-rate hsync/vsync that the line buffer and scanline stage consume. It also reports whether the input line timing is stable.

Parameters:
HCNT_WIDTH, 10, width of input/output pixel counters; the line buffer holds 2**HCNT_WIDTH pixels per half.
LOCK_LINES, 4, number of consecutive equal-length input lines required to assert locked.

Ports:
clk_sys  input  1  system clock
reset  input  1  synchronous active-high reset
bypass  input  1  1 = pass input timing straight through (no doubling)
ce_x1  input  1  input pixel clock enable
ce_x2  input  1  doubled-rate pixel clock enable
hs_in  input  1  source hsync, active high
vs_in  input  1  source vsync, active high
pe_in  output  1  buffer write enable, equals ce_x1 (combinational)
pe_out  output  1  buffer read/output enable, = bypass ? ce_x1 : ce_x2 (combinational)
hcnt  output  HCNT_WIDTH  write pixel index
sd_hcnt  output  HCNT_WIDTH  read pixel index
line_toggle  output  1  buffer half currently being written
hs_sd  output  1  doubled-rate hsync, active high
vs_sd  output  1  vsync re-timed to output line starts
line_len  output  HCNT_WIDTH  last measured input line length minus 1
hs_len  output  HCNT_WIDTH  last measured input hsync width in pixels
locked  output  1  input line length stable
overflow  output  1  sticky: an input line exceeded 2**HCNT_WIDTH pixels

Behaviour:
- Reset (synchronous, active high): all registered outputs and internal state are 0. This covers hcnt, sd_hcnt, line_toggle, hs_sd, vs_sd, line_len, hs_len, locked, overflow, the edge-detect registers and the lock counter. Reset overrides all other events in the same cycle. Reset mid-line restarts measurement from scratch.
- Input side: hs_in is sampled only on cycles with ce_x1=1; edges are detected against the previously sampled value.
  - Rising edge on a ce_x1 cycle: line_len <= hcnt; hcnt <= 0; line_toggle flips.
  - Otherwise, on ce_x1: hcnt increments. At all-ones it holds (no wrap) and sets overflow. overflow clears only on reset.
  - Falling edge on a ce_x1 cycle: hs_len <= hcnt+1, saturating at all-ones. The counter then continues normally.
- Lock state machine, 2 states, evaluated at each input hsync rising edge:
  - UNLOCKED: if hcnt == line_len, increment the match counter; otherwise clear it. When the counter reaches LOCK_LINES-1 matches, go to LOCKED.
  - LOCKED: any mismatch, or an overflow event, goes to UNLOCKED and clears the counter.
  - locked = (state == LOCKED). It is registered and changes in the cycle after the deciding edge.
- Output side, on pe_out:
  - sd_hcnt <= (sd_hcnt == line_len) ? 0 : sd_hcnt+1.
  - If an input hsync rising edge is detected in the same cycle, or is pending from an earlier cycle, sd_hcnt <= 0 instead and the pending flag clears.
  - An edge detected while pe_out=0 sets the pending flag.
  - Net effect: two output lines per input line, resynchronised every input line.
- hs_sd: registered on pe_out. hs_sd = 1 when the next sd_hcnt value < hs_len, else 0. If hs_len = 0, hs_sd stays 0.
- vs_sd: registered on pe_out. It takes vs_in only when the next sd_hcnt value is 0; otherwise it holds.
- bypass = 1:
  - pe_out = ce_x1.
  - sd_hcnt follows hcnt (sd_hcnt <= next hcnt on ce_x1).
  - hs_sd <= sampled hs_in; vs_sd <= vs_in on ce_x1.
  - Measurement and lock logic keep running.
- Latency:
  - hcnt/line_toggle: 1 clk after the ce_x1 cycle carrying the edge.
  - sd_hcnt/hs_sd: 1 clk after the applying pe_out.
- Edge cases:
  - ce_x1 and ce_x2 in the same cycle: both sides update independently.
  - A line of length 1 (two edges on consecutive ce_x1) is valid: line_len = 0, and sd_hcnt stays 0.

Test Plan:
1. Reset, then 800-pixel lines with hsync width 96, ce_x2 at twice the ce_x1 rate → line_len=799 and hs_len=96 after the first full line. line_toggle flips once per line. sd_hcnt runs 0..799 twice per input line, and hs_sd is high for the first 96 output pixels of each output line.
2. Feed 5 identical 800-pixel lines → locked rises exactly after the 4th matching edge. One 801-pixel line → locked falls the cycle after that edge. The 4th subsequent matching line re-locks.
3. Hold hs_in low for 1100 ce_x1 with HCNT_WIDTH=10 → hcnt saturates at 1023 and overflow=1, sticky until reset. locked=0.
4. Input hsync edge on a cycle with ce_x2=0 → sd_hcnt becomes 0 on the next pe_out, not earlier. The same edge coinciding with ce_x2=1 → sd_hcnt=0 after that cycle.
5. bypass=1 with 800/96 timing → pe_out == ce_x1, sd_hcnt == hcnt each pixel, and hs_sd is a 1-pixel-delayed copy of hs_in. Toggling bypass back to 0 gives correct doubled timing within one input line.
6. Assert reset mid-line (hcnt=400, locked=1) → next cycle all outputs are 0. Measurement restarts, and the first valid line_len appears after the second subsequent hsync edge.
